exibe_sequencia: RTL and testbench

- Playback engine for the memory game: reads the stored sequence back out of the jogadas memory and shows it on the LEDs, one entry at a time, before the player repeats it.
- It is the read/present side of the interface whose input/compare side the game control unit implements.
- It is started by the control unit at the start of each round and returns a one-cycle pronto when the last entry of the round has been shown.
- It owns the memory address only while ativo=1; the top level muxes endereco into the memory under ativo.

---
 rtl/exibe_sequencia.sv | 109 ++++++++++
 tb/tb_exibe_sequencia.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exibe_sequencia.sv
// Playback engine for the memory game: walks the jogadas memory from address 0
// to the latched round index, lighting each entry for ON_CICLOS then blanking for OFF_CICLOS.
module exibe_sequencia #(
  parameter int unsigned ON_CICLOS  = 500,
  parameter int unsigned OFF_CICLOS = 250,
  parameter int unsigned TIMER_W    = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic [3:0] dado_mem,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ativo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    MOSTRA  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam logic [TIMER_W-1:0] ON_LIM  = TIMER_W'(ON_CICLOS - 1);
  localparam logic [TIMER_W-1:0] OFF_LIM = TIMER_W'(OFF_CICLOS - 1);

  estado_t            estado_q, estado_d;
  logic [3:0]         endereco_q, endereco_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         rodada_q, rodada_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      timer_q    <= '0;
      rodada_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      timer_q    <= timer_d;
      rodada_q   <= rodada_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    timer_d    = timer_q;
    rodada_d   = rodada_q;
    leds       = '0;
    ativo      = 1'b0;
    pronto     = 1'b0;
    db_estado  = estado_q;
    case (estado_q)
      OCIOSO: begin
        if (iniciar) estado_d = CARREGA;
      end
      CARREGA: begin
        ativo      = 1'b1;
        endereco_d = '0;
        timer_d    = '0;
        rodada_d   = rodada;
        estado_d   = MOSTRA;
      end
      MOSTRA: begin
        ativo = 1'b1;
        leds  = dado_mem;
        if (timer_q == ON_LIM) begin
          timer_d  = '0;
          estado_d = APAGA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGA: begin
        ativo = 1'b1;
        if (timer_q == OFF_LIM) begin
          timer_d  = '0;
          estado_d = (endereco_q == rodada_q) ? FIM : PROXIMO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PROXIMO: begin
        // address advances a cycle before display so dado_mem is settled
        ativo      = 1'b1;
        endereco_d = endereco_q + 4'd1;
        estado_d   = MOSTRA;
      end
      FIM: begin
        pronto   = 1'b1;
        estado_d = OCIOSO;
      end
      default: begin
        db_estado = '1;
        estado_d  = OCIOSO;
      end
    endcase
  end

  assign endereco = endereco_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia: a timing model predicts lit intervals, the
// active window and the pronto pulse; a negedge monitor extracts and checks them.
module tb_exibe_sequencia;

  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] rodada = '0;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ativo;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  assign dado_mem = mem[endereco];

  exibe_sequencia #(.ON_CICLOS(ON), .OFF_CICLOS(OFF), .TIMER_W(10)) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .rodada(rodada),
    .dado_mem(dado_mem), .endereco(endereco), .leds(leds), .ativo(ativo),
    .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;   // 0 lit interval, 1 active window, 2 pronto pulse
    int         cyc;
    int         len;
    logic [3:0] val;
    logic [3:0] addr;
    int         x;      // lit: state-ok flag; active: proximo cycles
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  // reference model state
  bit busy = 0;
  int latch_at = 0;
  int end_at = 0;

  always @(posedge clock) begin
    if (reset_n) begin
      if (!busy) begin
        if (iniciar) begin
          busy = 1;
          latch_at = cyc + 1;
        end
      end else if (cyc == latch_at) begin
        int n;
        ev_t e;
        n = int'(rodada) + 1;
        for (int i = 0; i < n; i++) begin
          e.kind = 0; e.cyc = latch_at + 1 + i * (ON + OFF + 1); e.len = ON;
          e.val = mem[i]; e.addr = 4'(i); e.x = 1;
          sb.push_back(e);
        end
        end_at = latch_at + 1 + n * (ON + OFF) + (n - 1);
        e.kind = 1; e.cyc = latch_at; e.len = end_at - latch_at;
        e.val = '0; e.addr = '0; e.x = n - 1;
        sb.push_back(e);
        e.kind = 2; e.cyc = end_at; e.len = 1; e.val = '0; e.addr = rodada; e.x = 0;
        sb.push_back(e);
      end else if (cyc == end_at) begin
        busy = 0;
      end
    end
    cyc++;
  end

  task automatic pop_check(input ev_t g);
    ev_t w;
    string nm [3] = '{"lit", "active", "pronto"};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got cyc=%0d len=%0d val=%b addr=%0d x=%0d, want nothing",
               nm[g.kind], g.cyc, g.len, g.val, g.addr, g.x);
      return;
    end
    w = sb.pop_front();
    if (g.kind != w.kind || g.cyc != w.cyc || g.len != w.len || g.val != w.val ||
        g.addr != w.addr || g.x != w.x) begin
      bad++;
      $display("FAIL %s: got kind=%0d cyc=%0d len=%0d val=%b addr=%0d x=%0d, want kind=%0d cyc=%0d len=%0d val=%b addr=%0d x=%0d",
               nm[w.kind], g.kind, g.cyc, g.len, g.val, g.addr, g.x,
               w.kind, w.cyc, w.len, w.val, w.addr, w.x);
    end
  endtask

  // monitor
  bit in_lit = 0, in_act = 0;
  ev_t lit_ev, act_ev;

  always @(negedge clock) begin
    if (!reset_n) begin
      in_lit = 0;
      in_act = 0;
    end else begin
      if (leds != 4'b0) begin
        if (!in_lit) begin
          in_lit = 1;
          lit_ev.kind = 0; lit_ev.cyc = cyc; lit_ev.len = 0;
          lit_ev.val = leds; lit_ev.addr = endereco; lit_ev.x = 1;
        end
        lit_ev.len++;
        if (leds != lit_ev.val || db_estado != 4'd2 || !ativo) lit_ev.x = 0;
      end else if (in_lit) begin
        in_lit = 0;
        pop_check(lit_ev);
      end
      if (ativo) begin
        if (!in_act) begin
          in_act = 1;
          act_ev.kind = 1; act_ev.cyc = cyc; act_ev.len = 0;
          act_ev.val = '0; act_ev.addr = '0; act_ev.x = 0;
        end
        act_ev.len++;
        if (db_estado == 4'd4) act_ev.x++;
      end else if (in_act) begin
        in_act = 0;
        pop_check(act_ev);
      end
      if (pronto) begin
        ev_t p;
        p.kind = 2; p.cyc = cyc; p.len = 1; p.val = leds; p.addr = endereco; p.x = 0;
        pop_check(p);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clock) iniciar = 1'b1;
    @(negedge clock) iniciar = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    @(negedge clock) iniciar = 1'b0;
    n = 0;
    while ((busy || sb.size() != 0) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL idle_timeout: got %0d pending events want 0", sb.size());
      sb.delete();
      busy = 0;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_lit(input logic [3:0] v);
    int n;
    n = 0;
    while (leds != v && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("wait_lit", int'(leds), int'(v));
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << $urandom_range(0, 3));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'b0001;
    #1;
    chk("reset_leds", int'(leds), 0);
    chk("reset_ativo", int'(ativo), 0);
    chk("reset_pronto", int'(pronto), 0);
    chk("reset_estado", int'(db_estado), 0);
    chk("reset_endereco", int'(endereco), 0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;

    // directed three-entry playback
    mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
    rodada = 4'd2;
    pulse();
    wait_idle();

    // single entry
    rodada = 4'd0;
    pulse();
    wait_idle();

    // full sixteen entries, no wrap
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    rodada = 4'd15;
    pulse();
    wait_idle();
    chk("final_endereco", int'(endereco), 15);

    // rodada change and iniciar during mostra are ignored
    rodada = 4'd2;
    pulse();
    wait_lit(mem[0]);
    rodada = 4'd7;
    pulse();
    wait_idle();
    pulse();
    wait_idle();

    // iniciar held high: back-to-back playbacks
    rodada = 4'd1;
    @(negedge clock) iniciar = 1'b1;
    repeat (50) @(negedge clock);
    wait_idle();

    // reset during mostra
    mem[0] = 4'b0100;
    rodada = 4'd3;
    pulse();
    wait_lit(4'b0100);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_leds", int'(leds), 0);
    chk("async_ativo", int'(ativo), 0);
    chk("async_estado", int'(db_estado), 0);
    chk("async_pronto", int'(pronto), 0);
    sb.delete();
    busy = 0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_reset_estado", int'(db_estado), 0);
    chk("post_reset_ativo", int'(ativo), 0);
    chk("post_reset_endereco", int'(endereco), 0);

    // randomized playbacks with spurious iniciar and rodada changes
    for (int t = 0; t < 14; t++) begin
      rand_mem();
      rodada = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      pulse();
      for (int k = 0; k < int'($urandom_range(0, 40)); k++) begin
        @(negedge clock);
        iniciar = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) rodada = 4'($urandom_range(0, 15));
      end
      wait_idle();
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
